// File: rtl/speed_pkg.sv
// Shared plant-mode encoding and default sizing constants for the speed plant
// and the controller that drives it.
package speed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    COAST = 2'd2,
    BRAKE = 2'd3
  } plant_state_e;

  localparam int DEF_W    = 8;
  localparam int DEF_VMAX = 200;
  localparam int DEF_DRAG = 1;

endpackage

// File: rtl/speed_plant_tick_gen.sv
// Free-running divider: tick is high for one clk cycle out of every TICK_DIV,
// on the cycle where the counter sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/speed_plant.sv
// Discrete-time vehicle speed plant: commands are staged in a one-entry pending
// register, applied on each divider tick, and the clamped speed is streamed out.
module speed_plant
  import speed_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int TICK_DIV = 4,
  parameter int DRAG     = DEF_DRAG,
  parameter int VMAX     = DEF_VMAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_af,
  input  logic [W-1:0] cmd_bf,
  output logic         spd_valid,
  input  logic         spd_ready,
  output logic [W-1:0] spd_data,
  output logic [1:0]   state,
  output logic         sat,
  output logic         ovr
);

  localparam logic signed [W+1:0] DRAG_S = (W + 2)'(DRAG);
  localparam logic signed [W+1:0] VMAX_S = (W + 2)'(VMAX);
  localparam logic [W-1:0]        VMAX_W = W'(VMAX);

  logic         tick;
  logic         pend_v_q;
  logic [W-1:0] pend_af_q, pend_bf_q;
  logic [W-1:0] act_af_q, act_bf_q;
  logic [W-1:0] speed_q;
  logic         spd_valid_q, sat_q, ovr_q;
  plant_state_e state_q;

  logic                accept;
  logic [W-1:0]        sel_af, sel_bf, speed_d;
  logic signed [W+1:0] raw;
  logic                clamp;
  plant_state_e        state_d;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign accept = cmd_valid && !pend_v_q;

  // The tick edge that consumes a pending command also uses it for this update.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_af = act_af_q;
    sel_bf = act_bf_q;
    if (pend_v_q) begin
      sel_af = pend_af_q;
      sel_bf = pend_bf_q;
    end

    raw = $signed({2'b00, speed_q}) + $signed({2'b00, sel_af})
        - $signed({2'b00, sel_bf}) - DRAG_S;

    speed_d = raw[W-1:0];
    clamp   = 1'b0;
    if (raw < 0) begin
      speed_d = '0;
      clamp   = (sel_af != '0) || (sel_bf != '0);
    end else if (raw > VMAX_S) begin
      speed_d = VMAX_W;
      clamp   = 1'b1;
    end

    if (speed_d == '0 && sel_af == '0 && sel_bf == '0) state_d = IDLE;
    else if (sel_af > sel_bf)                           state_d = ACCEL;
    else if (sel_bf > sel_af)                           state_d = BRAKE;
    else                                                state_d = COAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q    <= 1'b0;
      act_af_q    <= '0;
      act_bf_q    <= '0;
      speed_q     <= '0;
      spd_valid_q <= 1'b0;
      state_q     <= IDLE;
      sat_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else if (tick) begin
      if (pend_v_q) begin
        act_af_q <= pend_af_q;
        act_bf_q <= pend_bf_q;
      end
      pend_v_q    <= accept;
      speed_q     <= speed_d;
      spd_valid_q <= 1'b1;
      state_q     <= state_d;
      if (clamp) sat_q <= 1'b1;
      if (spd_valid_q && !spd_ready) ovr_q <= 1'b1;
    end else begin
      if (accept) pend_v_q <= 1'b1;
      if (spd_valid_q && spd_ready) spd_valid_q <= 1'b0;
    end
  end

  // NOTE: pending payload is only meaningful while pend_v_q is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_af_q <= cmd_af;
      pend_bf_q <= cmd_bf;
    end
  end

  assign cmd_ready = !pend_v_q;
  assign spd_valid = spd_valid_q;
  assign spd_data  = speed_q;
  assign state     = state_q;
  assign sat       = sat_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_speed_plant.sv
// Directed bench for speed_plant with TICK_DIV=4, DRAG=1, VMAX=200; expected
// values are hand-computed from speed + af - bf - 1 clamped to [0, 200].
module tb_speed_plant;
  import speed_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_af = '0;
  logic [W-1:0] cmd_bf = '0;
  logic         spd_valid;
  logic         spd_ready = 1'b1;
  logic [W-1:0] spd_data;
  logic [1:0]   state;
  logic         sat;
  logic         ovr;

  int checks = 0;
  int errors = 0;

  speed_plant #(.W(W), .TICK_DIV(4), .DRAG(1), .VMAX(200)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_af    (cmd_af),
    .cmd_bf    (cmd_bf),
    .spd_valid (spd_valid),
    .spd_ready (spd_ready),
    .spd_data  (spd_data),
    .state     (state),
    .sat       (sat),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after release (counter = 0).
  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    spd_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  // Offers one command, then returns on the cycle after the tick that applied it.
  task automatic apply(input int af, input int bf);
    int n;
    n = 0;
    while (!cmd_ready && n < 16) begin step(); n++; end
    if (!cmd_ready) check("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_af    = W'(af);
    cmd_bf    = W'(bf);
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 16) begin step(); n++; end
    if (!cmd_ready) check("cmd_applied_timeout", 32'(cmd_ready), 1);
  endtask

  initial begin
    // Reset values
    do_reset();
    check("rst_valid", 32'(spd_valid), 0);
    check("rst_data",  32'(spd_data),  0);
    check("rst_state", 32'(state),     32'(IDLE));
    check("rst_sat",   32'(sat),       0);
    check("rst_ovr",   32'(ovr),       0);
    check("rst_ready", 32'(cmd_ready), 1);

    // Accelerate with exact cycle timing
    cmd_valid = 1'b1; cmd_af = 8'd10; cmd_bf = 8'd0;
    step();
    cmd_valid = 1'b0;
    check("acc_ready_c1", 32'(cmd_ready), 0);
    step();
    check("acc_ready_c2", 32'(cmd_ready), 0);
    step();
    check("acc_ready_c3", 32'(cmd_ready), 0);
    check("acc_valid_c3", 32'(spd_valid), 0);
    step();
    check("acc_ready_c4", 32'(cmd_ready), 1);
    check("acc_valid_c4", 32'(spd_valid), 1);
    check("acc_data_c4",  32'(spd_data),  9);
    check("acc_state_c4", 32'(state),     32'(ACCEL));
    repeat (4) step();
    check("acc_valid_c8", 32'(spd_valid), 1);
    check("acc_data_c8",  32'(spd_data),  18);

    // Climb to 195, then clamp high
    apply(178, 0);
    check("hi_pre_data", 32'(spd_data), 195);
    check("hi_pre_sat",  32'(sat),      0);
    apply(20, 0);
    check("hi_data",  32'(spd_data), 200);
    check("hi_sat",   32'(sat),      1);
    check("hi_state", 32'(state),    32'(ACCEL));
    apply(7, 7);
    check("coast_data",  32'(spd_data), 199);
    check("coast_state", 32'(state),    32'(COAST));

    // Clamp low, then idle on pure drag
    do_reset();
    apply(6, 0);
    check("lo_pre_data", 32'(spd_data), 5);
    check("lo_pre_sat",  32'(sat),      0);
    apply(0, 30);
    check("lo_data",  32'(spd_data), 0);
    check("lo_state", 32'(state),    32'(BRAKE));
    check("lo_sat",   32'(sat),      1);
    apply(0, 0);
    check("idle_data",  32'(spd_data), 0);
    check("idle_state", 32'(state),    32'(IDLE));
    check("idle_sat",   32'(sat),      1);

    // Overrun: two ticks without consuming
    do_reset();
    spd_ready = 1'b0;
    apply(5, 0);
    check("ovr_first_data", 32'(spd_data), 4);
    check("ovr_first_flag", 32'(ovr),      0);
    repeat (4) step();
    check("ovr_data",  32'(spd_data),  8);
    check("ovr_valid", 32'(spd_valid), 1);
    check("ovr_flag",  32'(ovr),       1);
    spd_ready = 1'b1;
    step();
    check("ovr_consumed", 32'(spd_valid), 0);
    check("ovr_sticky",   32'(ovr),       1);

    // Reset while a command is pending and a sample is unconsumed
    spd_ready = 1'b0;
    apply(3, 0);
    check("mid_pre_data", 32'(spd_data), 10);
    cmd_valid = 1'b1; cmd_af = 8'd50; cmd_bf = 8'd0;
    step();
    cmd_valid = 1'b0;
    check("mid_pre_pend",  32'(cmd_ready), 0);
    check("mid_pre_valid", 32'(spd_valid), 1);
    do_reset();
    check("mid_ready", 32'(cmd_ready), 1);
    check("mid_valid", 32'(spd_valid), 0);
    check("mid_ovr",   32'(ovr),       0);
    repeat (3) step();
    check("mid_valid_c3", 32'(spd_valid), 0);
    step();
    check("mid_valid_c4", 32'(spd_valid), 1);
    check("mid_data_c4",  32'(spd_data),  0);
    check("mid_state_c4", 32'(state),     32'(IDLE));
    check("mid_sat_c4",   32'(sat),       0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_plant.md
SPEED_PLANT -- requirements
Module: speed_plant

Interface
REQ-001 SHALL have parameter W, default 8, data width of command and speed words.
REQ-002 SHALL have parameter TICK_DIV, default 4, clk cycles per plant update tick (legal range 2..255).
REQ-003 SHALL have parameter DRAG, default 1, speed lost per tick regardless of command.
REQ-004 SHALL have parameter VMAX, default 200, upper speed clamp (VMAX < 2^W).
REQ-005 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  controller offers accelerate/brake command.
REQ-008 SHALL have port cmd_ready  output  1  plant can accept a command.
REQ-009 SHALL have port cmd_af  input  W  accelerate force, unsigned.
REQ-010 SHALL have port cmd_bf  input  W  brake force, unsigned.
REQ-011 SHALL have port spd_valid  output  1  new speed sample available.
REQ-012 SHALL have port spd_ready  input  1  controller consumes the sample.
REQ-013 SHALL have port spd_data  output  W  speed sample, unsigned.
REQ-014 SHALL have port state  output  2  plant mode: IDLE=0, ACCEL=1, COAST=2, BRAKE=3.
REQ-015 SHALL have port sat  output  1  sticky flag: a clamp at VMAX or 0 occurred.
REQ-016 SHALL have port ovr  output  1  sticky flag: an unconsumed sample was overwritten.

Function
REQ-017 SHALL hold a one-entry pending command register (pend_v, pend_af, pend_bf); cmd_ready = !pend_v.
REQ-018 SHALL accept a command when cmd_valid && cmd_ready, loading pend_af/pend_bf and setting pend_v.
REQ-019 SHALL run a tick counter 0..TICK_DIV-1, wrapping to 0; the tick cycle is the one where counter == TICK_DIV-1.
REQ-020 SHALL, on the tick edge, copy the pending command into the active command (act_af, act_bf) and clear pend_v if pend_v=1; otherwise the active command is kept.
REQ-021 SHALL NOT bypass: a command accepted on the tick cycle goes to pending and is applied at the following tick.
REQ-022 SHALL, on the tick edge, compute speed_next = speed + af - bf - DRAG in W+2-bit signed arithmetic, using the newly selected active command, then clamp to [0, VMAX].
REQ-023 SHALL set sat when the raw result is < 0 and the clamped speed differs from speed - DRAG behaviour with zero forces is excluded (speed=0, af=bf=0 does not set sat), or when the raw result is > VMAX.
REQ-024 SHALL, on the tick edge, load spd_data with speed_next and set spd_valid; spd_valid is visible the cycle after the tick cycle.
REQ-025 SHALL hold spd_valid and spd_data stable until spd_valid && spd_ready, which clears spd_valid.
REQ-026 SHALL, if a tick edge occurs while spd_valid=1 and spd_ready=0, overwrite spd_data with the newest value, keep spd_valid=1 and set ovr.
REQ-027 SHALL, if a tick edge coincides with spd_valid && spd_ready, treat the old sample as consumed (no ovr) and present the new sample with spd_valid=1.
REQ-028 SHALL update state on the tick edge from speed_next and the active command: IDLE if speed_next=0 and af=bf=0; ACCEL if af>bf; BRAKE if bf>af; else COAST.
REQ-029 SHALL keep state, speed and spd_data unchanged between tick edges.

Reset
REQ-030 SHALL, while rst=1, clear the tick counter, pend_v, act_af, act_bf, speed, spd_data, spd_valid, sat, ovr, and set state=IDLE; cmd_ready reads 1 from the first cycle after rst is released.
REQ-031 SHALL, on reset mid-operation, discard any pending command and any unconsumed sample; the first post-reset tick occurs on the TICK_DIV-th cycle after rst falls.

Structure
REQ-032 SHALL place the state encoding (IDLE/ACCEL/COAST/BRAKE) and default W/VMAX/DRAG constants in the shared package speed_pkg, reused by the controller.
REQ-033 SHALL factor the tick divider into sub-module tick_gen (params TICK_DIV; ports clk, rst, tick).

Verification (TICK_DIV=4, DRAG=1, VMAX=200)
REQ-034 SHALL check reset: rst held 3 cycles -> spd_valid=0, spd_data=0, state=IDLE, sat=0, ovr=0, cmd_ready=1.
REQ-035 SHALL check accel: af=10, bf=0 accepted cycle 0 after reset -> spd_data=9, state=ACCEL at cycle 4, 18 at cycle 8; cmd_ready 0 at cycles 1-3, then 1.
REQ-036 SHALL check high clamp: speed 195, af=20, bf=0 -> spd_data=200, sat=1.
REQ-037 SHALL check low clamp and idle: speed 5, af=0, bf=30 -> spd_data=0, state=BRAKE, sat=1; then af=bf=0 -> speed 0, state=IDLE, sat unchanged.
REQ-038 SHALL check overrun: spd_ready=0 across two ticks with af=5 from speed 0 -> spd_data=8 (latest), spd_valid=1, ovr=1; spd_ready pulse clears spd_valid.
REQ-039 SHALL check mid-operation reset: rst asserted with pend_v=1 and spd_valid=1 -> both cleared, next sample at cycle 4 after release equals 0 with state=IDLE.
